// File: rtl/car_spawner.sv
// Car spawner: LFSR lane pick, cooldown between cars, mover restart pulse.
// Define SPAWNER_DIFFICULTY_EN to shorten the cooldown as cars are retired.
module car_spawner #(
  parameter int          NUM_LANES       = 4,
  parameter int          LANE_LEFT       = 160,
  parameter int          LANE_PITCH      = 80,
  parameter int          COOLDOWN_FRAMES = 30,
  parameter int          MIN_COOLDOWN    = 8,
  parameter int          OFFSCREEN_Y     = 445,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic signed [10:0] carTopY,
  input  logic               collision,
  input  logic               moverFailed,
  output logic [10:0]        spawnX,
  output logic               moverResetN,
  output logic               active,
  output logic [7:0]         spawnCount
);

  localparam int LW = $clog2(NUM_LANES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_COOL   = 3'd1;
  localparam logic [2:0] S_SPAWN  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_RETIRE = 3'd4;

  localparam logic [LW-1:0]     LAST_LANE = LW'(NUM_LANES - 1);
  localparam logic signed [10:0] OFF_Y    = 11'(OFFSCREEN_Y);
  localparam logic [7:0]        COOL_INIT = 8'(COOLDOWN_FRAMES);
  localparam logic [10:0]       X_INIT    = 11'(LANE_LEFT);

  logic [2:0]    state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [10:0]   spawn_x_q, spawn_x_d;
  logic          mover_rst_n_q, mover_rst_n_d;
  logic          active_q, active_d;
  logic [7:0]    spawn_count_q, spawn_count_d;
  logic [LW-1:0] prev_lane_q, prev_lane_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [7:0]    cooldown;

  logic [LW-1:0] draw;
  logic [LW-1:0] pick;
  logic [7:0]    frame_inc;
  logic          hit;

  assign lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Never spawn twice in a row in the same lane.
  assign draw = lfsr_q[LW-1:0];
  assign pick = (draw == prev_lane_q) ? draw + LW'(1) : draw;

  assign frame_inc = frame_cnt_q + 8'd1;
  assign hit = collision | moverFailed | (carTopY >= OFF_Y);

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    lane_d        = lane_q;
    prev_lane_d   = prev_lane_q;
    spawn_x_d     = spawn_x_q;
    spawn_count_d = spawn_count_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          state_d     = S_COOL;
          frame_cnt_d = '0;
        end
        (state_q == S_COOL): begin
          if (startOfFrame) begin
            frame_cnt_d = frame_inc;
            if (frame_inc == cooldown) begin
              state_d   = S_SPAWN;
              lane_d    = pick;
              spawn_x_d = 11'(LANE_LEFT + LANE_PITCH * int'(pick));
            end
          end
        end
        (state_q == S_SPAWN): begin
          state_d = S_ACTIVE;
        end
        (state_q == S_ACTIVE): begin
          if (hit) begin
            state_d       = S_RETIRE;
            spawn_count_d = spawn_count_q + 8'd1;
            prev_lane_d   = lane_q;
          end
        end
        (state_q == S_RETIRE): begin
          state_d     = S_COOL;
          frame_cnt_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // spawnX was loaded on SPAWN entry, so it is settled a clk before this.
    mover_rst_n_d = !((state_q == S_SPAWN) && (state_d == S_ACTIVE));
    active_d      = (state_d == S_ACTIVE);
  end

`ifdef SPAWNER_DIFFICULTY_EN
  localparam logic [7:0] COOL_FLOOR = 8'(MIN_COOLDOWN);

  logic [7:0] cooldown_q, cooldown_d;

  always_comb begin
    cooldown_d = cooldown_q;
    if ((state_q == S_ACTIVE) && (state_d == S_RETIRE) &&
        (spawn_count_d[2:0] == 3'd0) && (cooldown_q > COOL_FLOOR))
      cooldown_d = cooldown_q - 8'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cooldown_q <= COOL_INIT;
    else         cooldown_q <= cooldown_d;
  end

  assign cooldown = cooldown_q;
`else
  assign cooldown = COOL_INIT;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      spawn_x_q     <= X_INIT;
      mover_rst_n_q <= 1'b1;
      active_q      <= 1'b0;
      spawn_count_q <= '0;
      prev_lane_q   <= LAST_LANE;
      lane_q        <= LAST_LANE;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      spawn_x_q     <= spawn_x_d;
      mover_rst_n_q <= mover_rst_n_d;
      active_q      <= active_d;
      spawn_count_q <= spawn_count_d;
      prev_lane_q   <= prev_lane_d;
      lane_q        <= lane_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign spawnX      = spawn_x_q;
  assign moverResetN = mover_rst_n_q;
  assign active      = active_q;
  assign spawnCount  = spawn_count_q;

endmodule

// File: tb/tb_car_spawner.sv
// Bench for car_spawner: behavioural model compared every cycle,
// directed lane/retire/enable/reset scenarios, then random traffic.
module tb_car_spawner;

  localparam int N = 4;
  localparam int M_IDLE   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_LAUNCH = 2;
  localparam int M_DRIVE  = 3;
  localparam int M_RETIRE = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic enable = 1'b0;
  logic collision = 1'b0;
  logic moverFailed = 1'b0;
  logic signed [10:0] carTopY = '0;
  logic [10:0] spawnX;
  logic moverResetN;
  logic active;
  logic [7:0] spawnCount;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  int m_mode, m_frames, m_lane, m_prev, m_cool;
  int exp_x, exp_cnt;
  logic exp_rstn, exp_act;

  always #5 clk = ~clk;

  car_spawner dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .enable(enable),
    .carTopY(carTopY),
    .collision(collision),
    .moverFailed(moverFailed),
    .spawnX(spawnX),
    .moverResetN(moverResetN),
    .active(active),
    .spawnCount(spawnCount)
  );

  // Reference model: what the outputs must be after each clock.
  always @(posedge clk or negedge resetN) begin : mdl
    logic [15:0] cur;
    int mode, fr, lane, prev, cool, x, cnt;
    logic rn;
    if (!resetN) begin
      m_lfsr   <= 16'hACE1;
      m_mode   <= M_IDLE;
      m_frames <= 0;
      m_lane   <= N - 1;
      m_prev   <= N - 1;
      m_cool   <= 30;
      exp_x    <= 160;
      exp_cnt  <= 0;
      exp_rstn <= 1'b1;
      exp_act  <= 1'b0;
    end else begin
      cur = m_lfsr;
      mode = m_mode; fr = m_frames; lane = m_lane; prev = m_prev;
      cool = m_cool; x = exp_x; cnt = exp_cnt; rn = 1'b1;
      if (!enable) begin
        mode = M_IDLE;
      end else begin
        case (mode)
          M_IDLE: begin mode = M_WAIT; fr = 0; end
          M_WAIT: if (startOfFrame) begin
            fr = fr + 1;
            if (fr == cool) begin
              lane = int'(cur) % N;
              if (lane == prev) lane = (lane + 1) % N;
              x = 160 + 80 * lane;
              mode = M_LAUNCH;
            end
          end
          M_LAUNCH: begin rn = 1'b0; mode = M_DRIVE; end
          M_DRIVE: if (collision || moverFailed || carTopY >= 445) begin
            cnt = (cnt + 1) % 256;
            prev = lane;
`ifdef SPAWNER_DIFFICULTY_EN
            if (cnt % 8 == 0 && cool > 8) cool = cool - 1;
`endif
            mode = M_RETIRE;
          end
          M_RETIRE: begin mode = M_WAIT; fr = 0; end
          default: mode = M_IDLE;
        endcase
      end
      m_lfsr   <= {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
      m_mode   <= mode;
      m_frames <= fr;
      m_lane   <= lane;
      m_prev   <= prev;
      m_cool   <= cool;
      exp_x    <= x;
      exp_cnt  <= cnt;
      exp_rstn <= rn;
      exp_act  <= (mode == M_DRIVE);
    end
  end

  always @(negedge clk) begin
    checks = checks + 4;
    if (int'(spawnX) != exp_x) begin
      errors++;
      $display("FAIL cyc_spawnX got %0d want %0d t=%0t", spawnX, exp_x, $time);
    end
    if (moverResetN !== exp_rstn) begin
      errors++;
      $display("FAIL cyc_moverResetN got %0b want %0b t=%0t", moverResetN, exp_rstn, $time);
    end
    if (active !== exp_act) begin
      errors++;
      $display("FAIL cyc_active got %0b want %0b t=%0t", active, exp_act, $time);
    end
    if (int'(spawnCount) != exp_cnt) begin
      errors++;
      $display("FAIL cyc_spawnCount got %0d want %0d t=%0t", spawnCount, exp_cnt, $time);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d t=%0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  // 29 frames, then hold the 30th until the LFSR draws idx.
  task automatic spawn_lane(input int idx, input int want_x, input string tag);
    int waited;
    waited = 0;
    repeat (29) pulse();
    chk({tag, "_early_act"}, int'(active), 0);
    chk({tag, "_early_mrn"}, int'(moverResetN), 1);
    while (int'(m_lfsr[1:0]) != idx && waited < 64) begin
      step();
      waited++;
    end
    if (waited >= 64) begin
      checks++;
      errors++;
      $display("FAIL %s_lfsr_wait got %0d want %0d", tag, waited, 64);
    end
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    chk({tag, "_x"}, int'(spawnX), want_x);
    chk({tag, "_spawn_mrn"}, int'(moverResetN), 1);
    chk({tag, "_spawn_act"}, int'(active), 0);
    step();
    chk({tag, "_pulse_mrn"}, int'(moverResetN), 0);
    chk({tag, "_pulse_act"}, int'(active), 1);
    step();
    chk({tag, "_post_mrn"}, int'(moverResetN), 1);
    chk({tag, "_post_act"}, int'(active), 1);
  endtask

  task automatic run_to_spawn(output int frames);
    frames = 0;
    while (m_mode == M_WAIT && frames < 300) begin
      pulse();
      frames++;
    end
    if (m_mode != M_DRIVE) begin
      checks++;
      errors++;
      $display("FAIL spawn_timeout got %0d want %0d", m_mode, M_DRIVE);
    end
  endtask

  initial begin
    int frames;
    int r, neg;
    repeat (3) step();
    chk("rst_x", int'(spawnX), 160);
    chk("rst_mrn", int'(moverResetN), 1);
    chk("rst_act", int'(active), 0);
    chk("rst_cnt", int'(spawnCount), 0);
    resetN = 1'b1;
    step();
    enable = 1'b1;
    step();

    spawn_lane(2, 320, "first");
    for (int v = 430; v <= 445; v++) begin
      carTopY = 11'(v);
      step();
      if (v < 445) chk("ramp_act", int'(active), 1);
    end
    carTopY = '0;
    chk("ramp_ret_act", int'(active), 0);
    chk("ramp_cnt", int'(spawnCount), 1);
    step();

    spawn_lane(2, 400, "prev2");
    collision = 1'b1;
    moverFailed = 1'b1;
    step();
    chk("both_act", int'(active), 0);
    chk("both_cnt", int'(spawnCount), 2);
    step();
    step();
    collision = 1'b0;
    moverFailed = 1'b0;
    chk("both_cnt_hold", int'(spawnCount), 2);

    spawn_lane(3, 160, "prev3");
    moverFailed = 1'b1;
    step();
    moverFailed = 1'b0;
    chk("mf_cnt", int'(spawnCount), 3);
    step();

    repeat (15) pulse();
    enable = 1'b0;
    step();
    chk("dis_act", int'(active), 0);
    enable = 1'b1;
    step();
    run_to_spawn(frames);
    chk("restart_frames", frames, 30);

    resetN = 1'b0;
    #1;
    chk("mid_rst_x", int'(spawnX), 160);
    chk("mid_rst_mrn", int'(moverResetN), 1);
    chk("mid_rst_act", int'(active), 0);
    chk("mid_rst_cnt", int'(spawnCount), 0);
    step();
    resetN = 1'b1;
    repeat (10) begin
      step();
      chk("post_rst_mrn", int'(moverResetN), 1);
    end
    run_to_spawn(frames);
    chk("post_rst_frames", frames, 30);

`ifdef SPAWNER_DIFFICULTY_EN
    for (int k = 1; k <= 184; k++) begin
      moverFailed = 1'b1;
      step();
      moverFailed = 1'b0;
      step();
      run_to_spawn(frames);
      if (k == 7)   chk("diff_k7", frames, 30);
      if (k == 8)   chk("diff_k8", frames, 29);
      if (k == 175) chk("diff_k175", frames, 9);
      if (k == 176) chk("diff_k176", frames, 8);
      if (k == 184) chk("diff_k184", frames, 8);
    end
`endif

    for (int c = 0; c < 4000; c++) begin
      enable = ($urandom_range(0, 399) != 0);
      startOfFrame = ($urandom_range(0, 2) == 0);
      collision = ($urandom_range(0, 49) == 0);
      moverFailed = ($urandom_range(0, 79) == 0);
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        carTopY = 11'($urandom_range(445, 1023));
      end else if (r == 1) begin
        neg = -int'($urandom_range(1, 1024));
        carTopY = 11'(neg);
      end else begin
        carTopY = 11'($urandom_range(0, 444));
      end
      resetN = ($urandom_range(0, 1999) != 0);
      step();
    end
    resetN = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/car_spawner.md
CAR_SPAWNER -- requirements
Module: car_spawner

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_LANES, 4, number of lanes; only 2, 4 or 8 are legal.
- LANE_LEFT, 160, X pixel of lane 0.
- LANE_PITCH, 80, X pixel distance between adjacent lanes.
- COOLDOWN_FRAMES, 30, frames to wait between retire and the next spawn.
- MIN_COOLDOWN, 8, lower bound on cooldown; used only when the Configuration macro is defined.
- OFFSCREEN_Y, 445, Y pixel value at or beyond which the car is retired.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- resetN, in, 1, asynchronous active-low reset.
- startOfFrame, in, 1, one-clk pulse at each frame start.
- enable, in, 1, game running.
- carTopY, in, 11 signed, current top-left Y of the spawned car.
- collision, in, 1, player hit the spawned car.
- moverFailed, in, 1, failure flag from the car's mover.
- spawnX, out, 11, X position for the mover to load at (re)start.
- moverResetN, out, 1, active-low restart pulse to the mover.
- active, out, 1, a car is on screen.
- spawnCount, out, 8, number of cars retired so far.

REQ-003 Reset is resetN, asynchronous, active-low; the clock is clk.

REQ-004 All outputs SHALL be driven directly from registers.

Function
REQ-005 The block SHALL contain a 16-bit Fibonacci LFSR (polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0) that advances on every clk.

REQ-006 The FSM states SHALL be IDLE, COOLDOWN, SPAWN, ACTIVE and RETIRE.

REQ-007 IDLE SHALL go to COOLDOWN when enable=1, loading the frame counter with 0.

REQ-008 COOLDOWN SHALL increment the frame counter on each startOfFrame, and SHALL go to SPAWN on the clk where the counter reaches the current cooldown value.

REQ-009 On entry to SPAWN, the lane index SHALL be the log2(NUM_LANES) LSBs of the LFSR.
- If that index equals the previous lane, the next lane SHALL be used instead (index+1, wrapping modulo NUM_LANES).

REQ-010 In SPAWN:
- spawnX SHALL be set to LANE_LEFT + index*LANE_PITCH.
- moverResetN SHALL be low for exactly one clk.
- The next state SHALL be ACTIVE.

REQ-011 spawnX SHALL be stable for at least one clk before moverResetN goes low and SHALL hold until the next SPAWN.

REQ-012 active SHALL be 1 in ACTIVE only.

REQ-013 ACTIVE SHALL go to RETIRE when collision=1, moverFailed=1, or carTopY >= OFFSCREEN_Y (signed compare).
- If these conditions occur together, they SHALL count as a single retire.

REQ-014 RETIRE SHALL last one clk, SHALL increment spawnCount (wrapping 255->0), SHALL store the previous lane, and SHALL go to COOLDOWN with the counter cleared.

REQ-015 If enable=0 in any state, the next state SHALL be IDLE with active=0 and moverResetN=1; spawnCount and the LFSR SHALL be kept.

REQ-016 A startOfFrame coinciding with a state transition SHALL be counted only if the FSM is in COOLDOWN on that clk.

Reset
REQ-017 On resetN=0, the block SHALL set:
- state = IDLE, LFSR = LFSR_SEED, spawnX = LANE_LEFT;
- moverResetN = 1, active = 0, spawnCount = 0;
- previous lane = NUM_LANES-1, frame counter = 0, cooldown = COOLDOWN_FRAMES.

REQ-018 Reset asserted mid-operation SHALL abort any spawn in progress, and no moverResetN pulse SHALL be issued after reset is released until a fresh COOLDOWN has completed.

Configuration
REQ-019 With macro SPAWNER_DIFFICULTY_EN defined, the cooldown value SHALL decrease by 1 at each RETIRE where spawnCount[2:0] becomes 0, saturating at MIN_COOLDOWN.

REQ-020 Without SPAWNER_DIFFICULTY_EN, the cooldown SHALL stay fixed at COOLDOWN_FRAMES and the difficulty logic SHALL not be synthesized.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset release, enable=1, 30 startOfFrame pulses -> SPAWN on the clk of the 30th pulse; moverResetN low for 1 clk; spawnX in {160,240,320,400}; active=1 on the next clk.
- In ACTIVE, carTopY ramped 430->445 -> RETIRE when 445 is reached; active=0; spawnCount=1; the next spawn follows 30 frames later.
- collision and moverFailed high together in ACTIVE -> spawnCount increments by exactly 1.
- LFSR forced so the drawn index equals the previous lane (2) -> spawnX=400 (lane 3); with previous lane 3 and index 3 -> spawnX=160.
- enable dropped during COOLDOWN at frame 15, then raised -> a full 30-frame wait restarts; resetN pulsed in ACTIVE -> all outputs return to their reset values.
- With SPAWNER_DIFFICULTY_EN defined, 8 retires -> the following cooldown is 29 frames; after 176 retires the cooldown is 8 and does not go lower.
